// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port round-robin arbiter onto a single memory port with timeout
module mem_port_arbiter #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_0,
    input  logic        i_we_0,
    input  logic [31:0] i_addr_0,
    input  logic [31:0] i_wdata_0,
    input  logic [3:0]  i_be_0,
    output logic        o_gnt_0,
    output logic        o_rvalid_0,
    output logic [31:0] o_rdata_0,
    output logic        o_err_0,
    input  logic        i_req_1,
    input  logic        i_we_1,
    input  logic [31:0] i_addr_1,
    input  logic [31:0] i_wdata_1,
    input  logic [3:0]  i_be_1,
    output logic        o_gnt_1,
    output logic        o_rvalid_1,
    output logic [31:0] o_rdata_1,
    output logic        o_err_1,
    input  logic        i_prog_mode,
    output logic        o_mem_access,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [31:0] CNT_LAST = 32'(TIMEOUT_CYC - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_ptr;
    logic        r_owner;
    logic        r_we;
    logic        r_err;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [31:0] r_cnt;
    logic [3:0]  r_be;
    logic        w_grant;
    logic        w_win;
    logic        w_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Grant is gated by rst so nothing leaks out combinationally while reset is held.
    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        w_win   = 1'b0;
        case (r_state)
            IDLE: begin
                if (rst && !i_prog_mode && (i_req_0 || i_req_1)) begin
                    w_grant = 1'b1;
                    w_win   = (i_req_0 && i_req_1) ? r_ptr : i_req_1;
                    w_next  = BUSY;
                end
            end
            BUSY: begin
                if (i_mem_valid || (r_cnt == CNT_LAST)) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr   <= 1'b0;
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
            r_be    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner <= w_win;
                        r_we    <= w_win ? i_we_1    : i_we_0;
                        r_addr  <= w_win ? i_addr_1  : i_addr_0;
                        r_wdata <= w_win ? i_wdata_1 : i_wdata_0;
                        r_be    <= w_win ? i_be_1    : i_be_0;
                        r_cnt   <= '0;
                    end
                end
                BUSY: begin
                    if (i_mem_valid) begin
                        r_rdata <= i_mem_rdata;
                        r_err   <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                DONE:    r_ptr <= ~r_ptr;
                default: ;
            endcase
        end
    end

    assign w_done       = (r_state == DONE);
    assign o_gnt_0      = w_grant & ~w_win;
    assign o_gnt_1      = w_grant & w_win;
    assign o_rvalid_0   = w_done & ~r_owner;
    assign o_rvalid_1   = w_done & r_owner;
    assign o_rdata_0    = o_rvalid_0 ? r_rdata : 32'd0;
    assign o_rdata_1    = o_rvalid_1 ? r_rdata : 32'd0;
    assign o_err_0      = o_rvalid_0 & r_err;
    assign o_err_1      = o_rvalid_1 & r_err;
    assign o_mem_access = (r_state == BUSY);
    assign o_mem_we     = o_mem_access & r_we;
    assign o_mem_addr   = r_addr;
    assign o_mem_wdata  = r_wdata;
    assign o_mem_be     = r_be;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_0, i_we_0, i_req_1, i_we_1;
    logic [31:0] i_addr_0, i_wdata_0, i_addr_1, i_wdata_1;
    logic [3:0]  i_be_0, i_be_1;
    logic        o_gnt_0, o_rvalid_0, o_err_0, o_gnt_1, o_rvalid_1, o_err_1;
    logic [31:0] o_rdata_0, o_rdata_1;
    logic        i_prog_mode, o_mem_access, o_mem_we, i_mem_valid;
    logic [31:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
    logic [3:0]  o_mem_be;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
        logic        chk_data;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .i_req_0(i_req_0), .i_we_0(i_we_0), .i_addr_0(i_addr_0), .i_wdata_0(i_wdata_0), .i_be_0(i_be_0),
        .o_gnt_0(o_gnt_0), .o_rvalid_0(o_rvalid_0), .o_rdata_0(o_rdata_0), .o_err_0(o_err_0),
        .i_req_1(i_req_1), .i_we_1(i_we_1), .i_addr_1(i_addr_1), .i_wdata_1(i_wdata_1), .i_be_1(i_be_1),
        .o_gnt_1(o_gnt_1), .o_rvalid_1(o_rvalid_1), .o_rdata_1(o_rdata_1), .o_err_1(o_err_1),
        .i_prog_mode(i_prog_mode), .o_mem_access(o_mem_access), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
        .i_mem_rdata(i_mem_rdata), .i_mem_valid(i_mem_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic p, input logic [31:0] d, input logic e, input logic c);
        exp_t x;
        x.port = p; x.rdata = d; x.err = e; x.chk_data = c;
        sb.push_back(x);
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_ctrl"}, {27'd0, o_gnt_0, o_gnt_1, o_rvalid_0, o_rvalid_1, o_mem_access}, 32'd0);
        chk({pfx, "_flags"}, {30'd0, o_err_0, o_err_1} | {31'd0, o_mem_we}, 32'd0);
        chk({pfx, "_rdata"}, o_rdata_0 | o_rdata_1, 32'd0);
        chk({pfx, "_memaddr"}, o_mem_addr, 32'd0);
        chk({pfx, "_memwdata"}, o_mem_wdata, 32'd0);
        chk({pfx, "_membe"}, {28'd0, o_mem_be}, 32'd0);
    endtask

    // Waits up to budget cycles for a completion pulse, then pops and compares.
    task automatic expect_done(input int budget);
        int   k = 0;
        exp_t e;
        while (!(o_rvalid_0 || o_rvalid_1) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("rvalid_seen", {31'd0, o_rvalid_0 | o_rvalid_1}, 32'd1);
        if ((o_rvalid_0 || o_rvalid_1) && sb.size() > 0) begin
            e = sb.pop_front();
            chk("rvalid_port", {30'd0, o_rvalid_1, o_rvalid_0}, e.port ? 32'd2 : 32'd1);
            if (e.chk_data)
                chk("rdata", e.port ? o_rdata_1 : o_rdata_0, e.rdata);
            chk("err", {31'd0, e.port ? o_err_1 : o_err_0}, {31'd0, e.err});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; i_prog_mode = 1'b0; i_mem_valid = 1'b0; i_mem_rdata = '0;
        i_req_0 = 0; i_we_0 = 0; i_addr_0 = '0; i_wdata_0 = '0; i_be_0 = '0;
        i_req_1 = 0; i_we_1 = 0; i_addr_1 = '0; i_wdata_1 = '0; i_be_1 = '0;
        repeat (3) @(negedge clk);
        check_zero("rst");
        i_req_0 = 1'b1; #1;
        chk("rst_gnt_blocked", {31'd0, o_gnt_0}, 32'd0);
        i_req_0 = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check_zero("post_rst");

        // Port 0 read, memory answers two cycles after grant
        i_req_0 = 1'b1; i_we_0 = 1'b0; i_addr_0 = 32'h40; i_be_0 = 4'hF; #1;
        chk("r35_gnt0", {31'd0, o_gnt_0}, 32'd1);
        chk("r35_gnt1", {31'd0, o_gnt_1}, 32'd0);
        push_exp(1'b0, 32'hDEADBEEF, 1'b0, 1'b1);
        @(negedge clk); i_req_0 = 1'b0;
        chk("r35_access", {31'd0, o_mem_access}, 32'd1);
        chk("r35_addr", o_mem_addr, 32'h40);
        chk("r35_we", {31'd0, o_mem_we}, 32'd0);
        @(negedge clk); i_mem_valid = 1'b1; i_mem_rdata = 32'hDEADBEEF;
        @(negedge clk); i_mem_valid = 1'b0; i_mem_rdata = '0;
        expect_done(0);
        chk("r35_access_low", {31'd0, o_mem_access}, 32'd0);
        @(negedge clk);
        chk("r35_single_pulse", {30'd0, o_rvalid_0, o_rvalid_1}, 32'd0);
        chk("r35_rdata_idle", o_rdata_0, 32'd0);

        // Port 1 write, request fields change after grant but memory side must hold
        i_req_1 = 1'b1; i_we_1 = 1'b1; i_addr_1 = 32'h100; i_wdata_1 = 32'h12345678; i_be_1 = 4'h3; #1;
        chk("r37_gnt1", {31'd0, o_gnt_1}, 32'd1);
        chk("r37_gnt0", {31'd0, o_gnt_0}, 32'd0);
        push_exp(1'b1, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        i_req_1 = 1'b0; i_we_1 = 1'b0; i_addr_1 = 32'hFFFFFFFF; i_wdata_1 = '0; i_be_1 = 4'hC;
        for (int i = 0; i < 4; i++) begin
            chk("r37_access", {31'd0, o_mem_access}, 32'd1);
            chk("r37_we", {31'd0, o_mem_we}, 32'd1);
            chk("r37_addr", o_mem_addr, 32'h100);
            chk("r37_wdata", o_mem_wdata, 32'h12345678);
            chk("r37_be", {28'd0, o_mem_be}, 32'd3);
            @(negedge clk);
        end
        i_mem_valid = 1'b1;
        @(negedge clk); i_mem_valid = 1'b0;
        expect_done(0);
        @(negedge clk);
        chk("r37_single_pulse", {31'd0, o_rvalid_1}, 32'd0);

        // Both ports request continuously: grants alternate starting at port 0
        i_req_0 = 1'b1; i_req_1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("r36_gnt0", {31'd0, o_gnt_0}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("r36_gnt1", {31'd0, o_gnt_1}, (i % 2 == 1) ? 32'd1 : 32'd0);
            push_exp((i % 2 == 1), 32'hA0000000 + i, 1'b0, 1'b1);
            @(negedge clk);
            chk("r36_busy_access", {31'd0, o_mem_access}, 32'd1);
            chk("r36_busy_nognt", {30'd0, o_gnt_0, o_gnt_1}, 32'd0);
            i_mem_valid = 1'b1; i_mem_rdata = 32'hA0000000 + i;
            @(negedge clk); i_mem_valid = 1'b0;
            expect_done(0);
            chk("r36_gap", {31'd0, o_mem_access}, 32'd0);
            chk("r36_done_nognt", {30'd0, o_gnt_0, o_gnt_1}, 32'd0);
            @(negedge clk);
        end
        i_req_0 = 1'b0; i_req_1 = 1'b0;

        // prog_mode blocks grants; rising during BUSY does not abort
        i_prog_mode = 1'b1; i_req_0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("r39_blocked", {30'd0, o_gnt_0, o_mem_access}, 32'd0);
            @(negedge clk);
        end
        i_prog_mode = 1'b0; #1;
        chk("r39_gnt0", {31'd0, o_gnt_0}, 32'd1);
        push_exp(1'b0, 32'h5A5A5A5A, 1'b0, 1'b1);
        @(negedge clk); i_req_0 = 1'b0; i_prog_mode = 1'b1;
        chk("r30_access", {31'd0, o_mem_access}, 32'd1);
        @(negedge clk); i_mem_valid = 1'b1; i_mem_rdata = 32'h5A5A5A5A;
        @(negedge clk); i_mem_valid = 1'b0;
        expect_done(0);
        i_prog_mode = 1'b0;
        @(negedge clk);

        // Stray mem_valid in IDLE is ignored
        i_mem_valid = 1'b1; i_mem_rdata = 32'h11111111;
        @(negedge clk); i_mem_valid = 1'b0;
        chk("r29_ignored", {29'd0, o_rvalid_0, o_rvalid_1, o_mem_access}, 32'd0);

        // Timeout: no mem_valid, 16 BUSY cycles then error completion
        i_req_0 = 1'b1; i_mem_rdata = 32'hBAD0BAD0; #1;
        chk("r38_gnt0", {31'd0, o_gnt_0}, 32'd1);
        push_exp(1'b0, 32'd0, 1'b1, 1'b1);
        @(negedge clk); i_req_0 = 1'b0;
        n_busy = 0;
        while (o_mem_access && n_busy < 100) begin
            n_busy++;
            @(negedge clk);
        end
        chk("r38_busy_cycles", n_busy, 32'd16);
        expect_done(0);
        @(negedge clk);
        i_req_1 = 1'b1; i_we_1 = 1'b0; #1;
        chk("r38_next_gnt1", {31'd0, o_gnt_1}, 32'd1);
        push_exp(1'b1, 32'h0BADF00D, 1'b0, 1'b1);
        @(negedge clk); i_req_1 = 1'b0; i_mem_valid = 1'b1; i_mem_rdata = 32'h0BADF00D;
        @(negedge clk); i_mem_valid = 1'b0;
        expect_done(0);
        @(negedge clk);

        // Reset mid-transaction drops it and returns priority to port 0
        i_req_1 = 1'b1; #1;
        chk("r40_gnt1", {31'd0, o_gnt_1}, 32'd1);
        @(negedge clk); i_req_1 = 1'b0;
        chk("r40_busy", {31'd0, o_mem_access}, 32'd1);
        rst = 1'b0; i_mem_valid = 1'b1;
        @(negedge clk);
        check_zero("r40_in_rst");
        @(negedge clk);
        check_zero("r40_in_rst2");
        rst = 1'b1;
        @(negedge clk); i_mem_valid = 1'b0;
        check_zero("r40_after");
        i_req_0 = 1'b1; i_req_1 = 1'b1; #1;
        chk("r40_ptr_gnt0", {31'd0, o_gnt_0}, 32'd1);
        chk("r40_ptr_gnt1", {31'd0, o_gnt_1}, 32'd0);
        push_exp(1'b0, 32'h00000077, 1'b0, 1'b1);
        @(negedge clk); i_req_0 = 1'b0; i_req_1 = 1'b0; i_mem_valid = 1'b1; i_mem_rdata = 32'h77;
        @(negedge clk); i_mem_valid = 1'b0;
        expect_done(0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1024, meaning max BUSY cycles waited for mem_valid before abort.
REQ-002 SHALL have clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have, per port p in {0,1}, req_p  input  1  access request, held until gnt_p.
REQ-005 SHALL have, per port p, we_p  input  1  1 = write, 0 = read.
REQ-006 SHALL have, per port p, addr_p  input  32  byte address.
REQ-007 SHALL have, per port p, wdata_p  input  32  write data.
REQ-008 SHALL have, per port p, be_p  input  4  byte enables.
REQ-009 SHALL have, per port p, gnt_p  output  1  request accepted this cycle.
REQ-010 SHALL have, per port p, rvalid_p  output  1  one-cycle completion pulse.
REQ-011 SHALL have, per port p, rdata_p  output  32  read data, valid with rvalid_p.
REQ-012 SHALL have, per port p, err_p  output  1  timeout flag, valid with rvalid_p.
REQ-013 SHALL have prog_mode  input  1  blocks new grants while high.
REQ-014 SHALL have mem_access, mem_we  output  1 each  downstream request and direction.
REQ-015 SHALL have mem_addr, mem_wdata  output  32 each; mem_be  output  4.
REQ-016 SHALL have mem_rdata  input  32; mem_valid  input  1  downstream completion.

Function
REQ-017 SHALL implement states IDLE, BUSY, DONE.
REQ-018 IDLE: if prog_mode=0 and any req_p=1, SHALL assert gnt of the winner combinationally, latch its we/addr/wdata/be, and go to BUSY.
REQ-019 Winner SHALL be chosen round-robin: a priority pointer names the favoured port; a sole requester always wins.
REQ-020 Pointer SHALL move to the other port on leaving DONE; it SHALL be unchanged otherwise.
REQ-021 At most one gnt_p SHALL be high in any cycle; gnt SHALL be 0 outside IDLE.
REQ-022 BUSY: mem_access=1, mem_* driven from latched registers, constant for the whole BUSY interval.
REQ-023 BUSY: on mem_valid=1 SHALL capture mem_rdata and go to DONE.
REQ-024 BUSY: a cycle counter SHALL count from 0; at TIMEOUT_CYC-1 without mem_valid, SHALL go to DONE with error set and captured data 0.
REQ-025 DONE: mem_access=0; rvalid_p=1 for latched winner only, rdata_p=captured data, err_p=error flag; next state IDLE.
REQ-026 mem_access SHALL be 0 for at least one cycle (DONE) between consecutive transactions.
REQ-027 Latency: gnt in cycle t -> mem_access from t+1 -> rvalid at one cycle after the mem_valid cycle; mem_valid at t+2 gives rvalid at t+3.
REQ-028 Writes SHALL complete identically to reads; rdata_p for writes is don't-care.
REQ-029 mem_valid outside BUSY SHALL be ignored.
REQ-030 prog_mode rising during BUSY SHALL NOT abort the transaction; completion or timeout proceeds normally.
REQ-031 rdata_p and err_p SHALL be 0 whenever rvalid_p=0.

Reset
REQ-032 On rst=0 at a clock edge: state IDLE, pointer = port 0, counter 0, latched fields 0.
REQ-033 During and after reset until next grant: all gnt, rvalid, err, mem_access, mem_we = 0; mem_addr, mem_wdata, mem_be, rdata = 0.
REQ-034 Reset mid-transaction SHALL drop it silently: no rvalid issued for it.

Verification
REQ-035 Port0 read addr 0x40, mem_valid 2 cycles after grant with mem_rdata 0xDEADBEEF -> rvalid_0 at t+3, rdata_0=0xDEADBEEF, err_0=0.
REQ-036 Both ports request continuously from reset -> grants alternate 0,1,0,1; no overlap; mem_access low one cycle between each.
REQ-037 Port1 write addr 0x100, wdata 0x12345678, be 0x3 -> mem_* held constant until mem_valid; rvalid_1 pulses once.
REQ-038 TIMEOUT_CYC=16, mem_valid never asserted -> rvalid_0 with err_0=1, rdata_0=0, exactly 16 BUSY cycles; next request served normally.
REQ-039 prog_mode=1 with req_0=1 -> gnt_0 stays 0; prog_mode=0 -> grant next cycle.
REQ-040 rst=0 during BUSY -> no rvalid, all outputs 0, pointer back to port 0.
